// File: rtl/mac_video_pkg.sv
// Shared definitions for the Mac video sampler: acquisition FSM states,
// default tuning values and the fixed Mac raster constants.
package mac_video_pkg;

    typedef enum logic [1:0] {
        NOSIG   = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Pixel-clock accumulator increment: default and saturation window.
    localparam logic [15:0] DEF_CTR_INC     = 16'd5133;
    localparam logic [15:0] DEF_CTR_INC_MIN = 16'd4800;
    localparam logic [15:0] DEF_CTR_INC_MAX = 16'd5500;

    // Sample offset within a pixel; lower bound is always 0.
    localparam logic [3:0]  DEF_OFS         = 4'd2;
    localparam logic [3:0]  DEF_OFS_MAX     = 4'd5;

    // Sync-loss timeout counter width (timeout = 2**W-1 cycles).
    localparam int          DEF_TIMEOUT_W   = 24;

    // Acceptable hsync count per frame, inclusive, and frames needed to lock.
    localparam logic [8:0]  DEF_LINES_MIN   = 9'd360;
    localparam logic [8:0]  DEF_LINES_MAX   = 9'd380;
    localparam logic [3:0]  DEF_LOCK_FRAMES = 4'd2;

    // Mac raster: visible pixels per line, visible lines, total pixels per line.
    localparam int          MAC_H_PIXELS    = 512;
    localparam int          MAC_V_LINES     = 342;
    localparam int          MAC_H_TOTAL     = 704;

endpackage

// File: rtl/sampler_ctrl_if.sv
// Bus bundle for sampler_ctrl: button/sync inputs, sampling controls and
// status outputs, plus the FSM state and shadow registers for observation.
//
// Strobe semantics: btn_strb[i] qualifies btn_val[i] for exactly one cycle.
// There is no back-pressure; the block consumes every strobe in the cycle it
// is seen, and a strobe with btn_val[i] low (a release) is ignored.
interface sampler_ctrl_if;
    logic [3:0]            btn_val;
    logic [3:0]            btn_strb;
    logic                  hsync_in;
    logic                  vsync_in;
    logic [15:0]           ctr_inc;
    logic [3:0]            samp_offset;
    logic                  line_start;
    logic                  frame_start;
    logic                  locked;
    logic                  signal_ok;
    mac_video_pkg::state_t fsm_state;
    logic [15:0]           shadow_inc;
    logic [3:0]            shadow_ofs;

    modport master (
        output btn_val, btn_strb, hsync_in, vsync_in,
        input  ctr_inc, samp_offset, line_start, frame_start, locked,
               signal_ok, fsm_state, shadow_inc, shadow_ofs
    );

    modport slave (
        input  btn_val, btn_strb, hsync_in, vsync_in,
        output ctr_inc, samp_offset, line_start, frame_start, locked,
               signal_ok, fsm_state, shadow_inc, shadow_ofs
    );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus history flop for one asynchronous sync input,
// producing a registered one-cycle pulse on the selected edge. The pulse
// appears three clock edges after the first edge that samples the new level.
module sync_edge_det #(
    parameter bit DETECT_RISE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic stage1;
    logic stage2;
    logic hist;
    logic edge_seen;

    // Synchronise the raw input and keep one cycle of history for edge compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1 <= 1'b0;
            stage2 <= 1'b0;
            hist   <= 1'b0;
        end else begin
            stage1 <= din;
            stage2 <= stage1;
            hist   <= stage2;
        end
    end

    assign edge_seen = DETECT_RISE ? (stage2 & ~hist) : (~stage2 & hist);

    // Register the edge so downstream logic sees a clean one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse <= 1'b0;
        end else begin
            pulse <= edge_seen;
        end
    end

endmodule

// File: rtl/sampler_ctrl.sv
// Sampling controller for a Mac video capture front end. Generates line and
// frame strobes from the raw syncs, judges each frame by its line count,
// acquires/holds lock, detects loss of sync and applies button adjustments to
// the pixel-clock increment and sample offset (deferred to frame boundaries
// while locked so a line is never sampled with mixed settings).
module sampler_ctrl
    import mac_video_pkg::*;
#(
    parameter logic [15:0] CTR_INC_DEF = DEF_CTR_INC,
    parameter logic [15:0] CTR_INC_MIN = DEF_CTR_INC_MIN,
    parameter logic [15:0] CTR_INC_MAX = DEF_CTR_INC_MAX,
    parameter logic [3:0]  OFS_DEF     = DEF_OFS,
    parameter logic [3:0]  OFS_MAX     = DEF_OFS_MAX,
    parameter int          TIMEOUT_W   = DEF_TIMEOUT_W,
    parameter logic [8:0]  LINES_MIN   = DEF_LINES_MIN,
    parameter logic [8:0]  LINES_MAX   = DEF_LINES_MAX,
    parameter logic [3:0]  LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic           clk,
    input  logic           rst_n,
    sampler_ctrl_if.slave  bus
);

    logic                 line_start;
    logic                 frame_start;
    logic [3:0]           press;
    logic [15:0]          shadow_inc;
    logic [3:0]           shadow_ofs;
    logic [15:0]          active_inc;
    logic [3:0]           active_ofs;
    logic [8:0]           line_cnt;
    logic                 frame_valid;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 signal_ok;
    logic                 timeout;
    state_t               state;
    state_t               state_nxt;
    logic [3:0]           vcnt;
    logic [3:0]           vcnt_nxt;

    // Mac hsync is active low: a line begins on its falling edge.
    sync_edge_det #(.DETECT_RISE(1'b0)) u_hsync_det (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.hsync_in),
        .pulse (line_start)
    );

    // A frame begins on the vsync rising edge.
    sync_edge_det #(.DETECT_RISE(1'b1)) u_vsync_det (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.vsync_in),
        .pulse (frame_start)
    );

    assign press = bus.btn_strb & bus.btn_val;

    // Shadow settings: saturating +/-1 per press; opposing presses cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_inc <= CTR_INC_DEF;
            shadow_ofs <= OFS_DEF;
        end else begin
            if (press[1] && !press[0] && (shadow_inc < CTR_INC_MAX)) begin
                shadow_inc <= shadow_inc + 16'd1;
            end else if (press[0] && !press[1] && (shadow_inc > CTR_INC_MIN)) begin
                shadow_inc <= shadow_inc - 16'd1;
            end
            if (press[3] && !press[2] && (shadow_ofs < OFS_MAX)) begin
                shadow_ofs <= shadow_ofs + 4'd1;
            end else if (press[2] && !press[3] && (shadow_ofs != 4'd0)) begin
                shadow_ofs <= shadow_ofs - 4'd1;
            end
        end
    end

    // Active settings follow the shadows, except that in lock they only move
    // at a frame boundary so the new values apply from the next line onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_inc <= CTR_INC_DEF;
            active_ofs <= OFS_DEF;
        end else if ((state != LOCKED) || frame_start) begin
            active_inc <= shadow_inc;
            active_ofs <= shadow_ofs;
        end
    end

    // Lines seen in the current frame; a new frame restarts the count, and a
    // line strobe coinciding with the frame strobe is the new frame's first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt <= 9'd0;
        end else if (frame_start) begin
            line_cnt <= line_start ? 9'd1 : 9'd0;
        end else if (line_start && (line_cnt != 9'h1FF)) begin
            line_cnt <= line_cnt + 9'd1;
        end
    end

    // The count still holds the finished frame in the frame_start cycle.
    assign frame_valid = (line_cnt >= LINES_MIN) && (line_cnt <= LINES_MAX);

    // Sync-loss watchdog: any sync strobe restarts it; it parks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '1;
        end else if (line_start || frame_start) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
        end
    end

    // signal_ok drops one cycle after the watchdog reaches all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signal_ok <= 1'b0;
        end else begin
            signal_ok <= ~(&tmo_cnt);
        end
    end

    // The cycle in which signal_ok is about to fall.
    assign timeout = signal_ok & (&tmo_cnt);

    // Acquisition state and valid-frame counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NOSIG;
            vcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            vcnt  <= vcnt_nxt;
        end
    end

    // Acquisition decisions are taken only at frame boundaries; loss of sync
    // overrides everything, including a frame boundary in the same cycle.
    always_comb begin
        state_nxt = state;
        vcnt_nxt  = vcnt;
        if (timeout) begin
            state_nxt = NOSIG;
        end else if (frame_start) begin
            case (state)
                NOSIG: begin
                    // The partial frame before the first vsync is never judged.
                    state_nxt = ACQUIRE;
                    vcnt_nxt  = 4'd0;
                end
                ACQUIRE: begin
                    if (frame_valid) begin
                        vcnt_nxt = vcnt + 4'd1;
                        if ((vcnt + 4'd1) >= LOCK_FRAMES) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        vcnt_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!frame_valid) begin
                        state_nxt = ACQUIRE;
                        vcnt_nxt  = 4'd0;
                    end
                end
                default: begin
                    state_nxt = NOSIG;
                    vcnt_nxt  = 4'd0;
                end
            endcase
        end
    end

    assign bus.ctr_inc     = active_inc;
    assign bus.samp_offset = active_ofs;
    assign bus.line_start  = line_start;
    assign bus.frame_start = frame_start;
    assign bus.locked      = (state == LOCKED);
    assign bus.signal_ok   = signal_ok;
    assign bus.fsm_state   = state;
    assign bus.shadow_inc  = shadow_inc;
    assign bus.shadow_ofs  = shadow_ofs;

endmodule

// File: tb/tb_sampler_ctrl.sv
// Bench for sampler_ctrl: directed button and sync sequences, a frame-level
// reference model compared every cycle, and hand-computed spot checks.
module tb_sampler_ctrl;
    import mac_video_pkg::*;

    localparam int TW      = 10;
    localparam int TMO_MAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    sampler_ctrl_if bus ();

    sampler_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Expected values visible after each clock edge. Sync pulses are derived
    // from the history of sampled input levels; lock is a streak of good frames.
    int   m_sh_inc = 5133, m_sh_ofs = 2, m_ctr = 5133, m_ofs = 2;
    int   m_lines = 0, m_idle = TMO_MAX, m_streak = 0;
    bit   m_sig = 0, m_track = 0, m_lock = 0, m_line = 0, m_frame = 0;
    bit [3:1] h_last = '0, v_last = '0;
    bit   mt_timeout, mt_valid;
    logic [3:0] mt_press;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_sh_inc = 5133; m_sh_ofs = 2; m_ctr = 5133; m_ofs = 2;
                m_lines = 0; m_idle = TMO_MAX; m_streak = 0;
                m_sig = 0; m_track = 0; m_lock = 0; m_line = 0; m_frame = 0;
                h_last = '0; v_last = '0;
            end else begin
                mt_press   = bus.btn_strb & bus.btn_val;
                mt_timeout = m_sig && (m_idle == TMO_MAX);
                if (!m_lock || m_frame) begin
                    m_ctr = m_sh_inc;
                    m_ofs = m_sh_ofs;
                end
                m_sh_inc = clamp(m_sh_inc + int'(mt_press[1]) - int'(mt_press[0]), 4800, 5500);
                m_sh_ofs = clamp(m_sh_ofs + int'(mt_press[3]) - int'(mt_press[2]), 0, 5);
                mt_valid = (m_lines >= 360) && (m_lines <= 380);
                if (mt_timeout) begin
                    m_track = 0;
                    m_lock  = 0;
                end else if (m_frame) begin
                    if (!m_track) begin
                        m_track  = 1;
                        m_streak = 0;
                    end else if (mt_valid) begin
                        m_streak++;
                        if (m_streak >= 2) m_lock = 1;
                    end else begin
                        m_streak = 0;
                        m_lock   = 0;
                    end
                end
                if (m_frame) m_lines = m_line ? 1 : 0;
                else if (m_line) m_lines = clamp(m_lines + 1, 0, 511);
                m_sig = (m_idle != TMO_MAX);
                if (m_line || m_frame) m_idle = 0;
                else m_idle = clamp(m_idle + 1, 0, TMO_MAX);
                m_line  = h_last[3] && !h_last[2];
                m_frame = !v_last[3] && v_last[2];
                h_last  = {h_last[2:1], bus.hsync_in};
                v_last  = {v_last[2:1], bus.vsync_in};
            end
        end
    end

    // ---------------- compare process ----------------
    state_t exp_state;
    initial begin
        forever begin
            @(negedge clk);
            exp_state = !m_track ? NOSIG : (m_lock ? LOCKED : ACQUIRE);
            check("line_start",  32'(bus.line_start),  32'(m_line));
            check("frame_start", 32'(bus.frame_start), 32'(m_frame));
            check("locked",      32'(bus.locked),      32'(m_lock));
            check("signal_ok",   32'(bus.signal_ok),   32'(m_sig));
            check("ctr_inc",     32'(bus.ctr_inc),     32'(m_ctr));
            check("samp_offset", 32'(bus.samp_offset), 32'(m_ofs));
            check("shadow_inc",  32'(bus.shadow_inc),  32'(m_sh_inc));
            check("shadow_ofs",  32'(bus.shadow_ofs),  32'(m_sh_ofs));
            check("fsm_state",   32'(bus.fsm_state),   32'(exp_state));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic press(input int i, input int times);
        repeat (times) begin
            @(negedge clk);
            bus.btn_val[i]  = 1'b1;
            bus.btn_strb[i] = 1'b1;
            @(negedge clk);
            bus.btn_val[i]  = 1'b0;
            bus.btn_strb[i] = 1'b0;
        end
    endtask

    task automatic press_pair(input logic [3:0] mask);
        @(negedge clk);
        bus.btn_val  = mask;
        bus.btn_strb = mask;
        @(negedge clk);
        bus.btn_val  = 4'd0;
        bus.btn_strb = 4'd0;
    endtask

    task automatic lines(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.hsync_in = 1'b0;
            repeat (2) @(negedge clk);
            bus.hsync_in = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic frame(input int n);
        @(negedge clk);
        bus.vsync_in = 1'b1;
        repeat (4) @(negedge clk);
        bus.vsync_in = 1'b0;
        repeat (2) @(negedge clk);
        lines(n);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    int n;
    initial begin
        rst_n        = 1'b0;
        bus.btn_val  = 4'd0;
        bus.btn_strb = 4'd0;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst ctr_inc",   32'(bus.ctr_inc), 32'd5133);
        check("rst samp_ofs",  32'(bus.samp_offset), 32'd2);
        check("rst locked",    32'(bus.locked), 32'd0);
        check("rst signal_ok", 32'(bus.signal_ok), 32'd0);
        check("rst state",     32'(bus.fsm_state), 32'(NOSIG));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single inc+ press: shadow first, active one cycle later.
        press(1, 1);
        check("inc+ shadow", 32'(bus.shadow_inc), 32'd5134);
        check("inc+ ctr lag", 32'(bus.ctr_inc), 32'd5133);
        @(negedge clk);
        check("inc+ ctr", 32'(bus.ctr_inc), 32'd5134);

        // Release strobe has no effect.
        @(negedge clk);
        bus.btn_strb[1] = 1'b1;
        @(negedge clk);
        bus.btn_strb[1] = 1'b0;
        @(negedge clk);
        check("release ignored", 32'(bus.shadow_inc), 32'd5134);

        // Down to 4805, then 10 more presses saturate at 4800.
        press(0, 329);
        check("inc at 4805", 32'(bus.shadow_inc), 32'd4805);
        press(0, 10);
        @(negedge clk);
        check("inc sat min", 32'(bus.shadow_inc), 32'd4800);
        check("ctr sat min", 32'(bus.ctr_inc), 32'd4800);
        press_pair(4'b0011);
        @(negedge clk);
        check("inc both", 32'(bus.shadow_inc), 32'd4800);

        // Offset: up to 5, saturate, cancel, down to 0, back to 2.
        press(3, 3);
        check("ofs at 5", 32'(bus.shadow_ofs), 32'd5);
        press(3, 1);
        check("ofs sat max", 32'(bus.shadow_ofs), 32'd5);
        press_pair(4'b1100);
        check("ofs both", 32'(bus.shadow_ofs), 32'd5);
        press(2, 6);
        @(negedge clk);
        check("ofs sat min", 32'(bus.samp_offset), 32'd0);
        press(3, 2);

        // Acquire: partial frame ignored, two good frames, lock on 3rd vsync.
        frame(370);
        check("sig ok after syncs", 32'(bus.signal_ok), 32'd1);
        frame(370);
        check("not yet locked", 32'(bus.locked), 32'd0);
        @(negedge clk);
        bus.vsync_in = 1'b1;
        n = 0;
        while (bus.locked !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("locked 3rd vsync", 32'(bus.locked), 32'd1);
        bus.vsync_in = 1'b0;
        repeat (2) @(negedge clk);

        // Mid-frame inc+ while locked: active value waits for frame_start.
        lines(100);
        press(1, 1);
        check("lk shadow", 32'(bus.shadow_inc), 32'd4801);
        check("lk ctr held", 32'(bus.ctr_inc), 32'd4800);
        lines(270);
        check("lk ctr held2", 32'(bus.ctr_inc), 32'd4800);
        @(negedge clk);
        bus.vsync_in = 1'b1;
        n = 0;
        while (bus.frame_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("lk fs seen", 32'(bus.frame_start), 32'd1);
        check("lk ctr at fs", 32'(bus.ctr_inc), 32'd4800);
        @(negedge clk);
        check("lk ctr after fs", 32'(bus.ctr_inc), 32'd4801);
        check("still locked", 32'(bus.locked), 32'd1);
        bus.vsync_in = 1'b0;
        repeat (2) @(negedge clk);

        // Short frame drops lock, two good frames relock.
        lines(300);
        frame(370);
        check("unlock short", 32'(bus.locked), 32'd0);
        check("unlock state", 32'(bus.fsm_state), 32'(ACQUIRE));
        frame(370);
        check("relock pending", 32'(bus.locked), 32'd0);
        @(negedge clk);
        bus.vsync_in = 1'b1;
        n = 0;
        while (bus.locked !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("relocked", 32'(bus.locked), 32'd1);
        bus.vsync_in = 1'b0;

        // Syncs stop: timeout returns to NOSIG.
        n = 0;
        while (bus.signal_ok !== 1'b0 && n < 1100) begin @(negedge clk); n++; end
        check("timeout sig", 32'(bus.signal_ok), 32'd0);
        check("timeout len", 32'(n >= 1000), 32'd1);
        check("timeout state", 32'(bus.fsm_state), 32'(NOSIG));
        check("timeout unlock", 32'(bus.locked), 32'd0);
        @(negedge clk);
        bus.vsync_in = 1'b1;
        n = 0;
        while (bus.fsm_state !== ACQUIRE && n < 10) begin @(negedge clk); n++; end
        check("reacquire", 32'(bus.fsm_state), 32'(ACQUIRE));
        bus.vsync_in = 1'b0;
        repeat (2) @(negedge clk);

        // Lock again, then reset mid-frame.
        frame(370);
        frame(370);
        frame(50);
        check("lock before rst", 32'(bus.locked), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async ctr",    32'(bus.ctr_inc), 32'd5133);
        check("async ofs",    32'(bus.samp_offset), 32'd2);
        check("async locked", 32'(bus.locked), 32'd0);
        check("async sig",    32'(bus.signal_ok), 32'd0);
        check("async state",  32'(bus.fsm_state), 32'(NOSIG));
        check("async shadow", 32'(bus.shadow_inc), 32'd5133);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no pulse after rst", 32'({bus.line_start, bus.frame_start}), 32'd0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sampler_ctrl.md
SAMPLER_CTRL -- requirements
Module: sampler_ctrl

Interface
REQ-001 Parameter CTR_INC_DEF, 5133: ctr_inc value after reset.
REQ-002 Parameter CTR_INC_MIN, 4800 / CTR_INC_MAX, 5500: saturation bounds for ctr_inc.
REQ-003 Parameter OFS_DEF, 2 / OFS_MAX, 5: samp_offset value after reset and its upper bound; lower bound is 0.
REQ-004 Parameter TIMEOUT_W, 24: sync-loss timeout is 2**TIMEOUT_W-1 clk cycles.
REQ-005 Parameter LINES_MIN, 360 / LINES_MAX, 380: valid hsync count per frame, inclusive.
REQ-006 Parameter LOCK_FRAMES, 2: number of consecutive valid frames required for lock.
REQ-007 clk  in  1  100 MHz system clock; the only clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 btn_val  in  4  debounced button levels; [0] inc-, [1] inc+, [2] ofs-, [3] ofs+.
REQ-010 btn_strb  in  4  one-cycle debounced change strobes, aligned with btn_val.
REQ-011 hsync_in, vsync_in  in  1 each  raw asynchronous Mac sync inputs.
REQ-012 ctr_inc  out  16  active pixel-clock accumulator increment.
REQ-013 samp_offset  out  4  active sample offset within a pixel.
REQ-014 line_start  out  1  one-cycle pulse on hsync falling edge.
REQ-015 frame_start  out  1  one-cycle pulse on vsync rising edge.
REQ-016 locked  out  1  high only in state LOCKED.
REQ-017 signal_ok  out  1  low when the sync-loss timeout has expired.

Function
REQ-018 Each sync input SHALL pass through two synchroniser flops plus one history flop; edges are detected between stage 2 and the history flop.
REQ-019 line_start/frame_start SHALL be registered and assert exactly 3 clk edges after the first edge that samples the new input level.
REQ-020 A button press SHALL be btn_strb[i] && btn_val[i]; a release has no effect.
REQ-021 Presses SHALL update shadow registers the next cycle: inc±1 on shadow_inc, ofs±1 on shadow_ofs, each saturating at its bounds.
REQ-022 Simultaneous presses of [0] and [1] (or of [2] and [3]) in the same cycle SHALL leave that shadow unchanged.
REQ-023 In LOCKED, ctr_inc/samp_offset SHALL load from the shadows only in the cycle frame_start asserts, so the change takes effect on the next line.
REQ-024 Outside LOCKED, ctr_inc/samp_offset SHALL track the shadows with one cycle of latency.
REQ-025 A 9-bit line counter SHALL increment on each line_start, saturate at 511, and clear on frame_start; frame_start and line_start in the same cycle yields count 1.
REQ-026 On frame_start, a frame is valid iff LINES_MIN <= count <= LINES_MAX; the counter value before clearing is evaluated.
REQ-027 The timeout counter SHALL clear on any line_start or frame_start, otherwise increment, and saturate at all-ones; signal_ok = not all-ones, registered.
REQ-028 FSM states: NOSIG, ACQUIRE, LOCKED; reset state NOSIG.
REQ-029 NOSIG -> ACQUIRE on the first frame_start; the valid-frame counter is cleared; the first partial frame is never judged.
REQ-030 ACQUIRE: each valid frame increments the valid-frame counter and each invalid frame clears it; -> LOCKED when the count reaches LOCK_FRAMES.
REQ-031 LOCKED -> ACQUIRE on an invalid frame, with the counter cleared.
REQ-032 In any state, a timeout (signal_ok falling) -> NOSIG; timeout takes priority over a same-cycle frame_start.

Reset
REQ-033 While rst_n is low, the block SHALL hold: ctr_inc = shadow_inc = CTR_INC_DEF; samp_offset = shadow_ofs = OFS_DEF; line_start = frame_start = locked = 0.
REQ-034 While rst_n is low, the block SHALL also hold: signal_ok = 0; timeout counter = all-ones; synchroniser and history flops = 0; line counter = 0; state = NOSIG.
REQ-035 Reset assertion mid-frame or mid-press SHALL take effect immediately; no pulse SHALL be generated on the first cycle after release.

Structure
REQ-036 A shared package mac_video_pkg SHALL hold the FSM state enum, the parameter defaults and the Mac line/pixel constants (512, 342, 704).
REQ-037 One sub-module, sync_edge_det (2-flop sync + edge pulse), SHALL be instantiated twice, once per sync input.

Verification
REQ-038 Reset, then one inc+ press -> shadow_inc 5134, ctr_inc 5134 one cycle later (NOSIG).
REQ-039 10 inc- presses from 4805 -> saturates at 4800; with ofs at 5, an ofs+ press -> stays at 5; simultaneous inc-/inc+ -> no change.
REQ-040 Three frames of 370 hsyncs -> locked after the 3rd vsync rise; an inc+ press mid-frame -> ctr_inc changes only in the next frame_start cycle.
REQ-041 Locked, then a frame of 300 lines -> ACQUIRE, locked = 0; then 2 valid frames -> relocks.
REQ-042 Stop both syncs for 2**24 cycles -> signal_ok = 0, state NOSIG; next vsync rise -> ACQUIRE.
REQ-043 Assert rst_n mid-frame while locked -> all outputs at reset values asynchronously; no spurious pulse after release.
